// File: rtl/cu_prefetch_stream_response_control_pkg.sv
// Shared types for the prefetch stream response controller: command/response/data lines,
// buffer status and the controller FSM states.
package cu_prefetch_stream_response_control_pkg;

  localparam int CU_ID_BITS          = 8;
  localparam int ARRAY_SIZE_BITS     = 32;
  localparam int CACHELINE_HALF_BITS = 512;

  localparam logic [CU_ID_BITS-1:0] PREFETCH_READ_CONTROL_ID = 8'h05;

  typedef enum logic [1:0] {
    RESP_DONE   = 2'd0,
    RESP_FAILED = 2'd1,
    RESP_AERROR = 2'd2,
    RESP_DERROR = 2'd3
  } resp_code_t;

  typedef struct packed {
    logic [CU_ID_BITS-1:0]      cu_id;
    logic [ARRAY_SIZE_BITS-1:0] real_size;
    logic [63:0]                address_offset;
  } CommandBufferLine;

  typedef struct packed {
    logic             valid;
    resp_code_t       response;
    CommandBufferLine cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic                           valid;
    CommandBufferLine               cmd;
    logic [CACHELINE_HALF_BITS-1:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic                             valid;
    logic [63:0]                      address_offest;
    logic [2*CACHELINE_HALF_BITS-1:0] data;
  } PrefetchDataLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } prefetch_state_t;

endpackage

// File: rtl/cu_prefetch_stream_response_control_if.sv
// Downstream handshake for assembled prefetch lines: the controller presents, the consumer accepts.
interface cu_prefetch_stream_response_control_if;
  import cu_prefetch_stream_response_control_pkg::*;

  PrefetchDataLine prefetch_data_out;
  logic            prefetch_data_ready_in;

  modport master (output prefetch_data_out, input prefetch_data_ready_in);
  modport slave  (input prefetch_data_out, output prefetch_data_ready_in);
endinterface

// File: rtl/cu_prefetch_stream_response_control_data_fifo.sv
// Synchronous FIFO for assembled cachelines; push into a full FIFO is honoured only
// when a pop frees the slot in the same cycle.
module cu_prefetch_data_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             alfull
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ALFULL = (AW+1)'(DEPTH-2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

  assign dout   = mem[rptr];
  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign alfull = (count >= CNT_ALFULL);
endmodule

// File: rtl/cu_prefetch_stream_response_control.sv
// Prefetch stream response control: counts command completions, pairs 64B halves into
// 128B lines, buffers them for the consumer and reports job done / error.
module cu_prefetch_stream_response_control
  import cu_prefetch_stream_response_control_pkg::*;
#(
  parameter logic [CU_ID_BITS-1:0] CU_PREFETCH_CONTROL_ID = PREFETCH_READ_CONTROL_ID,
  parameter int                    DATA_FIFO_DEPTH        = 16
) (
  input  logic                                         clock,
  input  logic                                         rstn,
  input  logic                                         enabled_in,
  input  logic [63:0]                                  total_size,
  input  ResponseBufferLine                            prefetch_response_in,
  input  ReadWriteDataLine                             read_data_0_in,
  input  ReadWriteDataLine                             read_data_1_in,
  cu_prefetch_stream_response_control_if.master        prefetch_data,
  output BufferStatus                                  prefetch_data_buffer_status,
  output logic [ARRAY_SIZE_BITS-1:0]                   prefetch_job_counter_done,
  output logic                                         prefetch_done,
  output logic                                         prefetch_error
);
  localparam int LINE_W = $bits(PrefetchDataLine) - 1;

  prefetch_state_t state, next_state;
  logic            enabled_r;
  logic [63:0]     total_r;
  logic            accept_rsp, accept_data;

  logic                     rsp_hit, rsp_bad, h0, h1;
  logic [ARRAY_SIZE_BITS:0] cnt_sum;
  logic [ARRAY_SIZE_BITS-1:0] cnt_next;
  logic                     reached;

  ReadWriteDataLine stage0, stage1, stage0_n, stage1_n, lo_sel, hi_sel;
  logic             push, pop, stage_err, overflow;
  logic [LINE_W-1:0] push_payload, fifo_dout;
  logic             fifo_empty, fifo_full, fifo_alfull;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (rstn) state <= IDLE;
    else      state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (enabled_r) next_state = (total_size == '0) ? DONE : ACTIVE;
      ACTIVE: if (reached) next_state = DRAIN;
      DRAIN:  if (fifo_empty && !stage0.valid && !stage1.valid) next_state = DONE;
      DONE:   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept_rsp  = 1'b0;
    accept_data = 1'b0;
    case (state)
      ACTIVE: begin
        accept_rsp  = enabled_r;
        accept_data = enabled_r;
      end
      IDLE, DRAIN: accept_data = enabled_r;
      default: ;
    endcase
  end

  assign rsp_hit  = accept_rsp && prefetch_response_in.valid
                    && (prefetch_response_in.cmd.cu_id == CU_PREFETCH_CONTROL_ID);
  assign rsp_bad  = rsp_hit && (prefetch_response_in.response != RESP_DONE);
  assign cnt_sum  = {1'b0, prefetch_job_counter_done} + {1'b0, prefetch_response_in.cmd.real_size};
  assign cnt_next = cnt_sum[ARRAY_SIZE_BITS] ? '1 : cnt_sum[ARRAY_SIZE_BITS-1:0];
  assign reached  = (64'(prefetch_job_counter_done) >= total_r);

  assign h0 = accept_data && read_data_0_in.valid
              && (read_data_0_in.cmd.cu_id == CU_PREFETCH_CONTROL_ID);
  assign h1 = accept_data && read_data_1_in.valid
              && (read_data_1_in.cmd.cu_id == CU_PREFETCH_CONTROL_ID);

  // A lone half waits in its stage; a repeat of an already staged half replaces it.
  always_comb begin
    push      = 1'b0;
    stage_err = 1'b0;
    lo_sel    = '0;
    hi_sel    = '0;
    stage0_n  = stage0;
    stage1_n  = stage1;
    if (h0 && h1) begin
      push   = 1'b1;
      lo_sel = read_data_0_in;
      hi_sel = read_data_1_in;
    end else if (h0) begin
      if (stage1.valid) begin
        push     = 1'b1;
        lo_sel   = read_data_0_in;
        hi_sel   = stage1;
        stage1_n = '0;
      end else begin
        stage_err = stage0.valid;
        stage0_n  = read_data_0_in;
      end
    end else if (h1) begin
      if (stage0.valid) begin
        push     = 1'b1;
        lo_sel   = stage0;
        hi_sel   = read_data_1_in;
        stage0_n = '0;
      end else begin
        stage_err = stage1.valid;
        stage1_n  = read_data_1_in;
      end
    end
    push_payload = {lo_sel.cmd.address_offset, hi_sel.data, lo_sel.data};
  end

  assign pop      = !fifo_empty && prefetch_data.prefetch_data_ready_in;
  assign overflow = push && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (rstn) begin
      enabled_r                 <= 1'b0;
      total_r                   <= '0;
      prefetch_job_counter_done <= '0;
      stage0                    <= '0;
      stage1                    <= '0;
      prefetch_error            <= 1'b0;
      prefetch_done             <= 1'b0;
    end else begin
      enabled_r <= enabled_in;
      if (state == IDLE && enabled_r) total_r <= total_size;
      if (rsp_hit) prefetch_job_counter_done <= cnt_next;
      stage0 <= stage0_n;
      stage1 <= stage1_n;
      if (rsp_bad || stage_err || overflow) prefetch_error <= 1'b1;
      prefetch_done <= (next_state == DONE);
    end
  end

  cu_prefetch_data_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (DATA_FIFO_DEPTH)
  ) u_data_fifo (
    .clock  (clock),
    .rstn   (rstn),
    .push   (push),
    .din    (push_payload),
    .pop    (pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .alfull (fifo_alfull)
  );

  assign prefetch_data.prefetch_data_out = fifo_empty ? '0 : {1'b1, fifo_dout};
  assign prefetch_data_buffer_status     = {fifo_alfull, fifo_full, fifo_empty};

  // Command fields beyond cu_id/size/offset travel with the lines but are not consumed here.
  logic unused_bits;
  assign unused_bits = ^{read_data_0_in, read_data_1_in, prefetch_response_in,
                         stage0, stage1, lo_sel, hi_sel};
endmodule

// File: tb/tb_cu_prefetch_stream_response_control.sv
// Directed bench for the prefetch stream response controller.
module tb_cu_prefetch_stream_response_control;
  import cu_prefetch_stream_response_control_pkg::*;

  localparam logic [7:0] ID      = PREFETCH_READ_CONTROL_ID;
  localparam logic [7:0] FOREIGN = 8'h09;

  logic                       clock = 1'b0;
  logic                       rstn;
  logic                       enabled_in;
  logic [63:0]                total_size;
  ResponseBufferLine          rsp;
  ReadWriteDataLine           rd0, rd1;
  BufferStatus                status;
  logic [ARRAY_SIZE_BITS-1:0] counter;
  logic                       done, error;

  cu_prefetch_stream_response_control_if pd_if ();

  cu_prefetch_stream_response_control dut (
    .clock                       (clock),
    .rstn                        (rstn),
    .enabled_in                  (enabled_in),
    .total_size                  (total_size),
    .prefetch_response_in        (rsp),
    .read_data_0_in              (rd0),
    .read_data_1_in              (rd1),
    .prefetch_data               (pd_if),
    .prefetch_data_buffer_status (status),
    .prefetch_job_counter_done   (counter),
    .prefetch_done               (done),
    .prefetch_error              (error)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic ReadWriteDataLine half_line(input bit hi, input int i, input logic [7:0] id);
    ReadWriteDataLine h;
    h                    = '0;
    h.valid              = 1'b1;
    h.cmd.cu_id          = id;
    h.cmd.real_size      = 32'd1;
    h.cmd.address_offset = 64'(i) << 7;
    h.data               = {16{(hi ? 32'h2000_0000 : 32'h1000_0000) + 32'(i)}};
    return h;
  endfunction

  function automatic logic [1023:0] exp_data(input int i);
    return {{16{32'h2000_0000 + 32'(i)}}, {16{32'h1000_0000 + 32'(i)}}};
  endfunction

  function automatic ResponseBufferLine rsp_line(input logic [7:0] id, input resp_code_t code,
                                                 input int sz);
    ResponseBufferLine r;
    r               = '0;
    r.valid         = 1'b1;
    r.response      = code;
    r.cmd.cu_id     = id;
    r.cmd.real_size = 32'(sz);
    return r;
  endfunction

  task automatic clr();
    rsp = '0;
    rd0 = '0;
    rd1 = '0;
  endtask

  task automatic drive_pair(input int i);
    rd0 = half_line(1'b0, i, ID);
    rd1 = half_line(1'b1, i, ID);
  endtask

  task automatic do_reset();
    rstn                         = 1'b1;
    enabled_in                   = 1'b0;
    total_size                   = '0;
    pd_if.prefetch_data_ready_in = 1'b0;
    clr();
    tick();
    tick();
    rstn = 1'b0;
  endtask

  task automatic start_job(input logic [63:0] n);
    enabled_in = 1'b1;
    total_size = n;
    tick();
    tick();
  endtask

  initial begin
    int seen, s_last, s_done;

    // reset state
    do_reset();
    rstn = 1'b1;
    tick();
    chk("rst_valid",   64'(pd_if.prefetch_data_out.valid), 64'd0);
    chk("rst_status",  64'(status), 64'b001);
    chk("rst_counter", 64'(counter), 64'd0);
    chk("rst_done",    64'(done), 64'd0);
    chk("rst_error",   64'(error), 64'd0);
    rstn = 1'b0;

    // four responses + four paired lines, ready high
    do_reset();
    start_job(64'd4);
    pd_if.prefetch_data_ready_in = 1'b1;
    seen = 0; s_last = -1; s_done = -1;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        rsp = rsp_line(ID, RESP_DONE, 1);
        drive_pair(c);
      end else clr();
      tick();
      if (pd_if.prefetch_data_out.valid === 1'b1) begin
        chk("full_data", 64'(pd_if.prefetch_data_out.data === exp_data(seen)), 64'd1);
        chk("full_offset", pd_if.prefetch_data_out.address_offest, 64'(seen) << 7);
        seen++;
        s_last = c;
      end
      if (done === 1'b1 && s_done < 0) s_done = c;
    end
    chk("full_lines",    64'(seen), 64'd4);
    chk("full_counter",  64'(counter), 64'd4);
    chk("full_done_lag", 64'(s_done - s_last), 64'd2);
    chk("full_error",    64'(error), 64'd0);

    // split halves: half-0, two idle cycles, half-1
    do_reset();
    start_job(64'd100);
    rd0 = half_line(1'b0, 7, ID);
    tick();
    clr();
    tick();
    tick();
    chk("split_gap_valid", 64'(pd_if.prefetch_data_out.valid), 64'd0);
    rd1 = half_line(1'b1, 7, ID);
    tick();
    clr();
    chk("split_valid", 64'(pd_if.prefetch_data_out.valid), 64'd1);
    chk("split_data",  64'(pd_if.prefetch_data_out.data === exp_data(7)), 64'd1);
    pd_if.prefetch_data_ready_in = 1'b1;
    tick();
    pd_if.prefetch_data_ready_in = 1'b0;
    chk("split_popped", 64'(pd_if.prefetch_data_out.valid), 64'd0);
    // second half-0 overwrites the stage
    rd0 = half_line(1'b0, 20, ID);
    tick();
    chk("ovw_err_before", 64'(error), 64'd0);
    rd0 = half_line(1'b0, 21, ID);
    tick();
    chk("ovw_err_after", 64'(error), 64'd1);
    rd0 = '0;
    rd1 = half_line(1'b1, 21, ID);
    tick();
    clr();
    chk("ovw_valid", 64'(pd_if.prefetch_data_out.valid), 64'd1);
    chk("ovw_data",  64'(pd_if.prefetch_data_out.data === exp_data(21)), 64'd1);

    // response filtering and error codes
    do_reset();
    start_job(64'd100);
    rsp = rsp_line(FOREIGN, RESP_DONE, 2);
    tick();
    clr();
    tick();
    chk("foreign_counter", 64'(counter), 64'd0);
    chk("foreign_error",   64'(error), 64'd0);
    chk("foreign_done",    64'(done), 64'd0);
    rsp = rsp_line(ID, RESP_DONE, 3);
    tick();
    chk("match_counter", 64'(counter), 64'd3);
    rsp = rsp_line(ID, RESP_FAILED, 2);
    tick();
    clr();
    chk("failed_error",   64'(error), 64'd1);
    chk("failed_counter", 64'(counter), 64'd5);
    enabled_in = 1'b0;
    tick();
    rsp = rsp_line(ID, RESP_DONE, 4);
    tick();
    clr();
    chk("disabled_counter", 64'(counter), 64'd5);

    // fill with ready low, then push+pop at full, then overflow
    do_reset();
    start_job(64'd100);
    for (int k = 1; k <= 16; k++) begin
      drive_pair(k - 1);
      tick();
      if (k == 13) chk("fill_alfull_13", 64'(status.alfull), 64'd0);
      if (k == 14) chk("fill_alfull_14", 64'(status.alfull), 64'd1);
      if (k == 15) chk("fill_full_15",   64'(status.full), 64'd0);
    end
    chk("fill_full_16", 64'(status.full), 64'd1);
    chk("fill_error",   64'(error), 64'd0);
    pd_if.prefetch_data_ready_in = 1'b1;
    drive_pair(16);
    tick();
    pd_if.prefetch_data_ready_in = 1'b0;
    chk("pushpop_full",  64'(status.full), 64'd1);
    chk("pushpop_head",  64'(pd_if.prefetch_data_out.data === exp_data(1)), 64'd1);
    chk("pushpop_error", 64'(error), 64'd0);
    drive_pair(17);
    tick();
    clr();
    chk("overflow_error", 64'(error), 64'd1);
    chk("overflow_full",  64'(status.full), 64'd1);
    chk("overflow_head",  64'(pd_if.prefetch_data_out.data === exp_data(1)), 64'd1);

    // reset mid-job with five buffered lines
    do_reset();
    start_job(64'd100);
    for (int k = 0; k < 5; k++) begin
      drive_pair(k);
      rsp = (k == 0) ? rsp_line(ID, RESP_DONE, 1) : ResponseBufferLine'('0);
      tick();
    end
    clr();
    chk("mid_pre_empty",   64'(status.empty), 64'd0);
    chk("mid_pre_counter", 64'(counter), 64'd1);
    rstn = 1'b1;
    tick();
    chk("mid_valid",   64'(pd_if.prefetch_data_out.valid), 64'd0);
    chk("mid_status",  64'(status), 64'b001);
    chk("mid_counter", 64'(counter), 64'd0);
    chk("mid_error",   64'(error), 64'd0);
    tick();
    chk("mid_valid_2", 64'(pd_if.prefetch_data_out.valid), 64'd0);
    rstn = 1'b0;

    // zero-size job goes straight to done
    do_reset();
    enabled_in = 1'b1;
    total_size = 64'd0;
    tick();
    chk("zero_done_early", 64'(done), 64'd0);
    tick();
    chk("zero_done", 64'(done), 64'd1);

    // counter overshooting total still completes
    do_reset();
    start_job(64'd2);
    rsp = rsp_line(ID, RESP_DONE, 7);
    tick();
    clr();
    chk("over_counter", 64'(counter), 64'd7);
    tick();
    chk("over_done_early", 64'(done), 64'd0);
    tick();
    chk("over_done", 64'(done), 64'd1);
    tick();
    chk("over_done_hold", 64'(done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
